// File: rtl/ntt_stage_ctrl_if.sv
// ==========================================================================
// ntt_stage_ctrl_if : start/stall, read/write strobes and addresses of an NTT stage sequencer
// Revision 1.0 -- initial release (optional inverse order: NTT_STAGE_CTRL_INTT_EN)
// ==========================================================================
`default_nettype none

interface ntt_stage_ctrl_if #(
  parameter int LOGN = 8
);
  logic            start;
  logic            stall;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_addr;
  logic            bf_valid;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;
  logic [LOGN-1:0] stage;
`ifdef NTT_STAGE_CTRL_INTT_EN
  logic            inv;
  logic            tw_inv;

  modport master (
    input  start, stall, inv,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid, wr_en, wr_addr_a, wr_addr_b, stage, tw_inv
  );
  modport slave (
    output start, stall, inv,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid, wr_en, wr_addr_a, wr_addr_b, stage, tw_inv
  );
`else
  modport master (
    input  start, stall,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid, wr_en, wr_addr_a, wr_addr_b, stage
  );
  modport slave (
    output start, stall,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid, wr_en, wr_addr_a, wr_addr_b, stage
  );
`endif
endinterface

`default_nettype wire

// File: rtl/ntt_stage_ctrl.sv
// ==========================================================================
// ntt_stage_ctrl : radix-2 NTT stage/butterfly sequencer; NTT_STAGE_CTRL_INTT_EN adds inverse stage order
// Revision 1.0 -- initial release
// ==========================================================================
`default_nettype none

module ntt_stage_ctrl #(
  parameter int LOGN    = 8,
  parameter int MUL_LAT = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  ntt_stage_ctrl_if.master bus
);

  localparam int              HALF       = 1 << (LOGN - 1);
  localparam int              TW_W       = LOGN - 1;
  localparam int              DW         = $clog2(MUL_LAT + 2);
  localparam logic [LOGN-1:0] K_LAST     = LOGN'(HALF - 1);
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(MUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [LOGN-1:0]   stage_q;
  logic [LOGN-1:0]   k_q;
  logic [DW-1:0]     drain_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [LOGN-1:0]   rd_a_q;
  logic [LOGN-1:0]   rd_b_q;
  logic [TW_W-1:0]   tw_q;

  logic [MUL_LAT:0]            vld_pipe_q;
  logic [MUL_LAT:0][LOGN-1:0]  a_pipe_q;
  logic [MUL_LAT:0][LOGN-1:0]  b_pipe_q;

  logic [LOGN-1:0] m_d, i_d, j_d, a_d, b_d;
  logic [TW_W-1:0] tw_d;
  logic [LOGN-1:0] first_stage_d, next_stage_d;
  logic            last_stage_d;

  // Butterfly (a, b, twiddle) for the current (stage, k) pair
  always_comb begin
    m_d  = LOGN'(1) << stage_q;
    i_d  = k_q & (m_d - LOGN'(1));
    j_d  = k_q >> stage_q;
    a_d  = (j_d << (stage_q + LOGN'(1))) + i_d;
    b_d  = a_d + m_d;
    tw_d = TW_W'(i_d << (STAGE_LAST - stage_q));
  end

`ifdef NTT_STAGE_CTRL_INTT_EN
  logic inv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_q <= 1'b0;
    end else if (state_q == S_IDLE && bus.start) begin
      inv_q <= bus.inv;
    end
  end

  // Inverse transforms walk the stages downwards, same per-stage formulas
  always_comb begin
    first_stage_d = bus.inv ? STAGE_LAST : '0;
    last_stage_d  = inv_q ? (stage_q == '0) : (stage_q == STAGE_LAST);
    next_stage_d  = inv_q ? (stage_q - LOGN'(1)) : (stage_q + LOGN'(1));
  end

  assign bus.tw_inv = inv_q;
`else
  always_comb begin
    first_stage_d = '0;
    last_stage_d  = (stage_q == STAGE_LAST);
    next_stage_d  = stage_q + LOGN'(1);
  end
`endif

  // Outputs are registered, so they trail the state by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      busy_q  <= (state_q == S_RUN) || (state_q == S_DRAIN);
      done_q  <= (state_q == S_DONE);
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_RUN;
            stage_q <= first_stage_d;
            k_q     <= '0;
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            rd_en_q <= 1'b1;
            rd_a_q  <= a_d;
            rd_b_q  <= b_d;
            tw_q    <= tw_d;
            if (k_q == K_LAST) begin
              k_q     <= '0;
              drain_q <= '0;
              state_q <= S_DRAIN;
            end else begin
              k_q <= k_q + LOGN'(1);
            end
          end
        end
        S_DRAIN: begin
          // Hold off the next stage until the last write of this one lands
          if (drain_q == DRAIN_LAST) begin
            if (last_stage_d) begin
              state_q <= S_DONE;
            end else begin
              stage_q <= next_stage_d;
              k_q     <= '0;
              state_q <= S_RUN;
            end
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Read strobe/addresses delayed to the butterfly input and write-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      a_pipe_q   <= '0;
      b_pipe_q   <= '0;
    end else begin
      vld_pipe_q[0] <= rd_en_q;
      a_pipe_q[0]   <= rd_a_q;
      b_pipe_q[0]   <= rd_b_q;
      for (int i = 1; i <= MUL_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        a_pipe_q[i]   <= a_pipe_q[i-1];
        b_pipe_q[i]   <= b_pipe_q[i-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a_q;
  assign bus.rd_addr_b = rd_b_q;
  assign bus.tw_addr   = tw_q;
  assign bus.stage     = stage_q;
  assign bus.bf_valid  = vld_pipe_q[0];
  assign bus.wr_en     = vld_pipe_q[MUL_LAT];
  assign bus.wr_addr_a = a_pipe_q[MUL_LAT];
  assign bus.wr_addr_b = b_pipe_q[MUL_LAT];

endmodule

`default_nettype wire

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 The block SHALL have parameter LOGN, default 8, meaning log2 of transform size; N = 2^LOGN.
REQ-002 The block SHALL have parameter MUL_LAT, default 6, meaning cycles from butterfly operand arrival to modmul/butterfly result.
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one full transform, sampled in IDLE only.
REQ-006 The block SHALL have port stall, input, 1 bit: when high in RUN, the block issues no read that cycle.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse at transform completion.
REQ-009 The block SHALL have port rd_en, output, 1 bit: coefficient read strobe, one butterfly per cycle.
REQ-010 The block SHALL have ports rd_addr_a and rd_addr_b, outputs, LOGN bits each: butterfly operand addresses.
REQ-011 The block SHALL have port tw_addr, output, LOGN-1 bits: twiddle ROM index for the issued butterfly.
REQ-012 The block SHALL have port bf_valid, output, 1 bit: operands valid at the butterfly/modmul input, equal to rd_en delayed 1 cycle.
REQ-013 The block SHALL have port wr_en, output, 1 bit: result write strobe, equal to rd_en delayed 1+MUL_LAT cycles.
REQ-014 The block SHALL have ports wr_addr_a and wr_addr_b, outputs, LOGN bits each: rd_addr_a/b delayed 1+MUL_LAT cycles.
REQ-015 The block SHALL have port stage, output, LOGN-bit-wide counter: current stage index.

Function
REQ-016 The block SHALL use an FSM with states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE SHALL go to RUN with stage=0 and k=0 when start=1; start in any other state SHALL be ignored.
REQ-018 In RUN with stall=0, the block SHALL assert rd_en and compute, with m=2^stage, j=k>>stage, i=k&(m-1): rd_addr_a=(j<<(stage+1))+i, rd_addr_b=rd_addr_a+m, tw_addr=i<<(LOGN-1-stage); k SHALL then increment.
REQ-019 In RUN with stall=1, the block SHALL deassert rd_en and hold k; in-flight bf_valid/wr_en delay lines SHALL keep advancing.
REQ-020 RUN SHALL go to DRAIN after issuing the butterfly with k=N/2-1.
REQ-021 DRAIN SHALL last exactly MUL_LAT+1 cycles so that every stage write completes before the next stage reads (no read-after-write overlap between stages).
REQ-022 At the end of DRAIN, if stage<LOGN-1, the block SHALL increment stage, set k=0 and go to RUN; otherwise it SHALL go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-024 Timing without stall: if start is sampled at edge T0, rd_en SHALL be high in cycles T0+1..T0+N/2; stage s SHALL begin at T0+1+s*(N/2+MUL_LAT+1); done SHALL be high at T0+1+LOGN*(N/2+MUL_LAT+1).
REQ-025 Address arithmetic SHALL be modulo 2^LOGN with no wrap in legal operation; k SHALL wrap to 0 at each stage change.

Reset
REQ-026 On reset_n=0, state SHALL be IDLE, stage and k SHALL be 0, delay lines SHALL be cleared, and all outputs SHALL be 0, immediately and asynchronously.
REQ-027 On reset mid-transform, the transform SHALL be abandoned with no wr_en after deassertion; the next start SHALL begin a fresh transform at stage 0.

Configuration
REQ-028 With macro NTT_STAGE_CTRL_INTT_EN defined, the block SHALL add an input port inv (1 bit), sampled with start, and an output port tw_inv equal to the latched inv.
REQ-029 When inv=1, stages SHALL run from LOGN-1 down to 0 (Gentleman-Sande order) with the same per-stage address formulas and timing.
REQ-030 Without NTT_STAGE_CTRL_INTT_EN, the inv and tw_inv ports SHALL be absent and operation SHALL be forward only.

Verification
REQ-031 LOGN=3, MUL_LAT=2, start at T0, stall=0: (a,b,tw) per stage SHALL be s0 (0,1,0)(2,3,0)(4,5,0)(6,7,0); s1 (0,2,0)(1,3,2)(4,6,0)(5,7,2); s2 (0,4,0)(1,5,1)(2,6,2)(3,7,3); done SHALL be at T0+22.
REQ-032 Same configuration: each wr_en and wr_addr_a/b SHALL match the rd_en and rd_addr_a/b from exactly 3 cycles earlier; the last write SHALL be at T0+21.
REQ-033 stall=1 for 2 cycles during stage 1, k=2: the address sequence SHALL be unchanged and done SHALL be at T0+24.
REQ-034 start pulsed again at T0+5, then reset_n low at T0+10: the second start SHALL be ignored; after reset all outputs SHALL be 0, there SHALL be no wr_en, and a new start SHALL reproduce REQ-031.
REQ-035 With NTT_STAGE_CTRL_INTT_EN and inv=1, LOGN=3: the s2 pairs SHALL be issued first and the s0 pairs last, tw_inv=1 throughout, and done SHALL be at T0+22.
REQ-036 Defaults LOGN=8, MUL_LAT=6: done SHALL be at T0+1081, busy SHALL be high from T0+1 to T0+1080, and there SHALL be 1024 wr_en pulses.
